index_vector_decoder: RTL and testbench

- Sequential counterpart to the priority encoder: accepts a stream of binary indices and emits the decoded 2^WIDTH-bit vector for each one.
- Indices enter through a valid/ready handshake and are buffered in a small FIFO.
- A registered output stage presents each decoded vector with its own valid/ready handshake.
- Feeds vector-consuming logic and is the stimulus source that encoder checks compare against.

---
 rtl/index_vector_decoder_if.sv | 15 +
 rtl/index_vector_decoder.sv | 65 ++++++
 tb/tb_index_vector_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/index_vector_decoder_if.sv
// index_vector_decoder_if: index-in / vector-out handshake bundle for index_vector_decoder.
interface index_vector_decoder_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             inNumber;
  logic                         inValid;
  logic                         inReady;
  logic [(1<<WIDTH)-1:0]        outVector;
  logic                         outValid;
  logic                         outReady;
  logic [$clog2(DEPTH+1)-1:0]   pending;
  modport master (output inNumber, inValid, outReady, input inReady, outVector, outValid, pending);
  modport slave  (input inNumber, inValid, outReady, output inReady, outVector, outValid, pending);
endinterface

// File: rtl/index_vector_decoder.sv
// index_vector_decoder: FIFO-buffered index stream decoded to 2^WIDTH-bit vectors behind a registered output stage.
// THERMO_MODE_EN selects thermometer decode (bits [i:0]); otherwise one-hot.
module index_vector_decoder #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  index_vector_decoder_if.slave bus
);
  localparam int VW = 1 << WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  function automatic logic [VW-1:0] decode(input logic [WIDTH-1:0] i);
`ifdef THERMO_MODE_EN
    return (VW'(2) << i) - VW'(1);
`else
    return VW'(1) << i;
`endif
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic             vld_q, vld_d;
  logic             push, pop;

  assign bus.inReady   = rst_n && (cnt_q < PW'(DEPTH));
  assign bus.outVector = vec_q;
  assign bus.outValid  = vld_q;
  assign bus.pending   = cnt_q;

  // Full/empty come from the occupancy count; pointers just wrap.
  always_comb begin
    push  = bus.inValid && bus.inReady;
    pop   = (cnt_q != '0) && (!vld_q || bus.outReady);
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + PW'(push) - PW'(pop);
    vld_d = pop || (vld_q && !bus.outReady);
    vec_d = pop ? decode(mem_q[rd_q]) : (vld_q && !bus.outReady) ? vec_q : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.inNumber;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: tb/tb_index_vector_decoder.sv
// tb_index_vector_decoder: randomized and directed checks of index_vector_decoder against a queue-based model.
module tb_index_vector_decoder;
  localparam int WIDTH = 3;
  localparam int DEPTH = 4;
  localparam int VW = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  index_vector_decoder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  index_vector_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [VW-1:0] ref_dec(input int i);
    logic [VW-1:0] v;
    v = '0;
`ifdef THERMO_MODE_EN
    for (int j = 0; j <= i; j++) v[j] = 1'b1;
`else
    v[i] = 1'b1;
`endif
    return v;
  endfunction

  function automatic int prio(input logic [VW-1:0] v);
    int r;
    r = -1;
    for (int j = 0; j < VW; j++) if (v[j]) r = j;
    return r;
  endfunction

  // Reference: a queue of accepted indices plus one output slot.
  int m_q[$];
  logic m_vld = 1'b0;
  logic [VW-1:0] m_vec = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_vld = 1'b0;
      m_vec = '0;
    end else begin
      automatic bit pu = bus.inValid && (m_q.size() < DEPTH);
      automatic bit po = (m_q.size() > 0) && (!m_vld || bus.outReady);
      if (po) begin
        m_vec = ref_dec(m_q.pop_front());
        m_vld = 1'b1;
      end else if (m_vld && bus.outReady) begin
        m_vld = 1'b0;
        m_vec = '0;
      end
      if (pu) m_q.push_back(int'(bus.inNumber));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_inReady", 32'(bus.inReady), 32'(rst_n && (m_q.size() < DEPTH)));
      chk("m_outValid", 32'(bus.outValid), 32'(m_vld));
      chk("m_outVector", 32'(bus.outVector), 32'(m_vec));
      chk("m_pending", 32'(bus.pending), 32'(m_q.size()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] tv [3];
    int ti [3];
`ifdef THERMO_MODE_EN
    tv[0] = 8'h01; tv[1] = 8'h0F; tv[2] = 8'hFF;
`else
    tv[0] = 8'h01; tv[1] = 8'h08; tv[2] = 8'h80;
`endif
    ti[0] = 0; ti[1] = 3; ti[2] = 7;
    bus.inNumber = '0;
    bus.inValid = 1'b1;
    bus.outReady = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_inReady", 32'(bus.inReady), 0);
      chk("rst_outValid", 32'(bus.outValid), 0);
      chk("rst_outVector", 32'(bus.outVector), 0);
      chk("rst_pending", 32'(bus.pending), 0);
    end
    step();
    rst_n = 1'b1;
    bus.inValid = 1'b0;
    #1 chk("rel_inReady", 32'(bus.inReady), 1);
    // basic latency
    bus.outReady = 1'b1;
    step();
    bus.inNumber = 3'd5;
    bus.inValid = 1'b1;
    step();
    bus.inValid = 1'b0;
    chk("lat_early", 32'(bus.outValid), 0);
    step();
    chk("lat_valid", 32'(bus.outValid), 1);
`ifdef THERMO_MODE_EN
    chk("lat_vec", 32'(bus.outVector), 32'h3F);
`else
    chk("lat_vec", 32'(bus.outVector), 32'h20);
`endif
    step();
    chk("lat_clr_v", 32'(bus.outValid), 0);
    chk("lat_clr_d", 32'(bus.outVector), 0);
    // back-pressure to full
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.inNumber = 3'(i);
      bus.inValid = 1'b1;
      step();
    end
    bus.inValid = 1'b0;
    repeat (2) begin
      chk("bp_vec", 32'(bus.outVector), 32'h01);
      chk("bp_pending", 32'(bus.pending), 4);
      chk("bp_inReady", 32'(bus.inReady), 0);
      step();
    end
    bus.outReady = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("drain_vec", 32'(bus.outVector), 32'(ref_dec(k)));
      chk("drain_pending", 32'(bus.pending), 32'(4 - k));
    end
    step();
    chk("drain_end", 32'(bus.outValid), 0);
    // simultaneous push/pop at pending=2
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.inNumber = 3'(i + 2);
      bus.inValid = 1'b1;
      step();
    end
    chk("sim_pre", 32'(bus.pending), 2);
    bus.outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.inNumber = 3'($urandom_range(7));
      step();
      chk("sim_pending", 32'(bus.pending), 2);
    end
    bus.inValid = 1'b0;
    repeat (4) step();
    // reset mid-stream
    bus.outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.inNumber = 3'(i + 1);
      bus.inValid = 1'b1;
      step();
    end
    bus.inValid = 1'b0;
    chk("mr_pending", 32'(bus.pending), 3);
    chk("mr_valid", 32'(bus.outValid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_clr_v", 32'(bus.outValid), 0);
    chk("mr_clr_d", 32'(bus.outVector), 0);
    chk("mr_clr_p", 32'(bus.pending), 0);
    chk("mr_clr_r", 32'(bus.inReady), 0);
    step();
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    bus.inNumber = 3'd7;
    bus.inValid = 1'b1;
    step();
    bus.inValid = 1'b0;
    step();
    chk("mr_vec", 32'(bus.outVector), 32'(ref_dec(7)));
    step();
    chk("mr_only", 32'(bus.outValid), 0);
    // decode table and priority-encoder round trip
    for (int i = 0; i < 3; i++) begin
      bus.inNumber = 3'(ti[i]);
      bus.inValid = 1'b1;
      step();
      if (i > 0) begin
        chk("tab_vec", 32'(bus.outVector), 32'(tv[i-1]));
        chk("tab_prio", 32'(prio(bus.outVector)), 32'(ti[i-1]));
      end
    end
    bus.inValid = 1'b0;
    step();
    chk("tab_vec", 32'(bus.outVector), 32'(tv[2]));
    chk("tab_prio", 32'(prio(bus.outVector)), 32'(ti[2]));
    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.inNumber = 3'($urandom_range(7));
      bus.inValid = ($urandom_range(3) != 0);
      bus.outReady = ($urandom_range(2) != 0);
      step();
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    repeat (8) step();
    chk("end_empty", 32'(bus.pending), 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
